// File: rtl/trap_csr_seq.sv
// Trap entry / mret CSR sequencer: walks the mepc/mcause/mstatus/mtvec accesses and issues a fetch redirect.
// Optional macro TRAP_VECTORED_EN enables vectored trap targets (mtvec mode 2'b01 with an interrupt cause).
module trap_csr_seq #(
  parameter logic [1:0] MTVEC_MODE_MASK = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  output logic        exc_ready_o,
  output logic [31:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic        csr_except_o,
  input  logic [31:0] csr_rdata_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] ADDR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_EPC, S_WR_CAUSE, S_RD_EPC, S_WT_EPC, S_RD_STAT,
    S_WT_STAT, S_WR_STAT, S_RD_TVEC, S_WT_TVEC, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        mret_q;
  logic [31:0] pc_q, cause_q, mstatus_q, redirect_pc_q;
  logic [29:0] epc_q;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b00;
    return r;
  endfunction

`ifdef TRAP_VECTORED_EN
  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (((tvec[1:0] & MTVEC_MODE_MASK) == 2'b01) && cause[31])
      return base + {cause[29:0], 2'b00};
    return base;
  endfunction
`else
  function automatic logic [31:0] trap_target(input logic [31:0] tvec);
    return {tvec[31:2], 2'b00};
  endfunction
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (exc_valid_i)  state_d = S_WR_EPC;
        else if (mret_i)  state_d = S_RD_EPC;
      end
      S_WR_EPC:   state_d = S_WR_CAUSE;
      S_WR_CAUSE: state_d = S_RD_STAT;
      S_RD_EPC:   state_d = S_WT_EPC;
      S_WT_EPC:   state_d = S_RD_STAT;
      S_RD_STAT:  state_d = S_WT_STAT;
      S_WT_STAT:  state_d = S_WR_STAT;
      S_WR_STAT:  state_d = mret_q ? S_DONE : S_RD_TVEC;
      S_RD_TVEC:  state_d = S_WT_TVEC;
      S_WT_TVEC:  state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // CSR writes are signalled on csr_except_o; csr_we_o is never asserted by this master.
  always_comb begin
    csr_addr_o       = 32'h0;
    csr_wdata_o      = 32'h0;
    csr_we_o         = 1'b0;
    csr_re_o         = 1'b0;
    csr_except_o     = 1'b0;
    redirect_valid_o = 1'b0;
    unique case (state_q)
      S_WR_EPC: begin
        csr_except_o = 1'b1;
        csr_addr_o   = ADDR_MEPC;
        csr_wdata_o  = pc_q;
      end
      S_WR_CAUSE: begin
        csr_except_o = 1'b1;
        csr_addr_o   = ADDR_MCAUSE;
        csr_wdata_o  = cause_q;
      end
      S_RD_EPC: begin
        csr_re_o   = 1'b1;
        csr_addr_o = ADDR_MEPC;
      end
      S_RD_STAT: begin
        csr_re_o   = 1'b1;
        csr_addr_o = ADDR_MSTATUS;
      end
      S_WR_STAT: begin
        csr_except_o = 1'b1;
        csr_addr_o   = ADDR_MSTATUS;
        csr_wdata_o  = mret_q ? mret_mstatus(mstatus_q) : trap_mstatus(mstatus_q);
      end
      S_RD_TVEC: begin
        csr_re_o   = 1'b1;
        csr_addr_o = ADDR_MTVEC;
      end
      S_DONE:  redirect_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign exc_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign redirect_pc_o = redirect_pc_q;

  // Read data arrives in the WAIT state after each read, registered by the CSR file.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mret_q        <= 1'b0;
      pc_q          <= 32'h0;
      cause_q       <= 32'h0;
      mstatus_q     <= 32'h0;
      epc_q         <= 30'h0;
      redirect_pc_q <= 32'h0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (exc_valid_i) begin
            mret_q  <= 1'b0;
            pc_q    <= exc_pc_i;
            cause_q <= exc_cause_i;
          end else if (mret_i) begin
            mret_q <= 1'b1;
          end
        end
        S_WT_EPC:  epc_q     <= csr_rdata_i[31:2];
        S_WT_STAT: mstatus_q <= csr_rdata_i;
        S_WR_STAT: if (mret_q) redirect_pc_q <= {epc_q, 2'b00};
`ifdef TRAP_VECTORED_EN
        S_WT_TVEC: redirect_pc_q <= trap_target(csr_rdata_i, cause_q);
`else
        S_WT_TVEC: redirect_pc_q <= trap_target(csr_rdata_i);
`endif
        default: ;
      endcase
    end
  end

endmodule
